// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the calculator engine.
//   - opcode encodings (ADD/SUB/MUL/DIV)
//   - error code encodings (none/overflow/divide-by-zero)
//   - engine FSM state enum
//   - pow10(): elaboration-time 10^n used for the display range limits
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_DZ   = 2'b10;

   typedef enum logic [1:0] {IDLE, EXEC, ITER, CHECK} state_t;

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/calc_engine_if.sv
// calc_engine_if: request/response bundle of the calculator engine.
//   master: drives i_start, i_op, i_s1/i_s2 (+signs), i_clear_err
//   slave : drives o_busy, o_done, o_result, o_sign, o_err, o_err_code
interface calc_engine_if #(parameter int W = 40);
   logic         i_start;
   logic [1:0]   i_op;
   logic [W-1:0] i_s1;
   logic [W-1:0] i_s2;
   logic         i_s1_sign;
   logic         i_s2_sign;
   logic         i_clear_err;
   logic         o_busy;
   logic         o_done;
   logic [W-1:0] o_result;
   logic         o_sign;
   logic         o_err;
   logic [1:0]   o_err_code;

   modport master (
      output i_start, i_op, i_s1, i_s2, i_s1_sign, i_s2_sign, i_clear_err,
      input  o_busy, o_done, o_result, o_sign, o_err, o_err_code
   );

   modport slave (
      input  i_start, i_op, i_s1, i_s2, i_s1_sign, i_s2_sign, i_clear_err,
      output o_busy, o_done, o_result, o_sign, o_err, o_err_code
   );
endinterface

// File: rtl/calc_seq_muldiv.sv
// calc_seq_muldiv: iterative unsigned multiply / restoring divide core.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_load         : latch operands and start (i_mode 0 = a*b, 1 = a/b)
//   i_a, i_b       : W-bit magnitudes
//   o_p            : 2W-bit product, or zero-extended quotient
//   o_valid        : one-cycle pulse after W iterations; o_p holds until next load
module calc_seq_muldiv #(
   parameter int W = 40
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_load,
   input  logic           i_mode,
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic [2*W-1:0] o_p,
   output logic           o_valid
);
   localparam int CW = $clog2(W + 1);

   // hi/lo: {accumulator, multiplier} for MUL, {remainder, dividend/quotient} for DIV
   logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic          mode_q, mode_d, run_q, run_d, valid_q, valid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W:0]    mul_sum, trial;
   logic [W-1:0]  trial_diff;
   logic          trial_ge;

   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      mode_d  = mode_q;
      run_d   = run_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;

      mul_sum    = {1'b0, hi_q} + {1'b0, b_q};
      // remainder is always < divisor, so the shifted trial fits W+1 bits
      trial      = {hi_q, lo_q[W-1]};
      trial_ge   = trial >= {1'b0, b_q};
      trial_diff = W'(trial - {1'b0, b_q});

      if (i_load) begin
         hi_d   = '0;
         lo_d   = i_mode ? i_a : i_b;
         b_d    = i_mode ? i_b : i_a;
         mode_d = i_mode;
         cnt_d  = '0;
         run_d  = 1'b1;
      end else if (run_q) begin
         if (mode_q) begin
            hi_d = trial_ge ? trial_diff : trial[W-1:0];
            lo_d = {lo_q[W-2:0], trial_ge};
         end else if (lo_q[0]) begin
            {hi_d, lo_d} = {mul_sum, lo_q[W-1:1]};
         end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[W-1:1]};
         end
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(W - 1)) begin
            run_d   = 1'b0;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         run_q   <= 1'b0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign o_p     = mode_q ? {{W{1'b0}}, lo_q} : {hi_q, lo_q};
   assign o_valid = valid_q;
endmodule

// File: rtl/calc_engine.sv
// calc_engine: sign-magnitude ADD/SUB/MUL/DIV engine with display range check.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : start/op/operands/clear in, busy/done/result/sign/err out
// Flow: IDLE -> EXEC (add/sub) or ITER (mul/div) or CHECK (div by zero)
//       -> CHECK (range check, outputs update, o_done) -> IDLE.
module calc_engine
   import calc_pkg::*;
#(
   parameter int W      = 40,
   parameter int DIGITS = 6
) (
   input logic         i_clk,
   input logic         i_reset,
   calc_engine_if.slave bus
);
   localparam logic [W-1:0] POS_LIM = W'(pow10(DIGITS) - 64'd1);
   localparam logic [W-1:0] NEG_LIM = W'(pow10(DIGITS - 1) - 64'd1);

   state_t        state_q, state_d;
   logic [1:0]    op_q, op_d, code_q, code_d;
   logic [W-1:0]  s1_q, s1_d, s2_q, s2_d, mag_q, mag_d, result_q, result_d;
   logic          s1s_q, s1s_d, s2s_q, s2s_d, carry_q, carry_d, rsign_q, rsign_d;
   logic          dz_q, dz_d, sign_q, sign_d, err_q, err_d, busy_q, busy_d, done_q, done_d;

   logic           accept, div_zero, core_load, core_valid;
   logic [2*W-1:0] core_p;
   logic [W:0]     add_sum;
   logic           s2_eff;
   logic [W-1:0]   chk_mag;
   logic           chk_hi, chk_sign, ovf;

   assign accept    = (state_q == IDLE) && bus.i_start && !err_q && !bus.i_clear_err;
   assign div_zero  = (bus.i_op == OP_DIV) && (bus.i_s2 == '0);
   assign core_load = accept && bus.i_op[1] && !div_zero;

   calc_seq_muldiv #(.W(W)) u_core (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (core_load),
      .i_mode  (bus.i_op[0]),
      .i_a     (bus.i_s1),
      .i_b     (bus.i_s2),
      .o_p     (core_p),
      .o_valid (core_valid)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      s1s_d    = s1s_q;
      s2s_d    = s2s_q;
      mag_d    = mag_q;
      carry_d  = carry_q;
      rsign_d  = rsign_q;
      dz_d     = dz_q;
      result_d = result_q;
      sign_d   = sign_q;
      err_d    = err_q;
      code_d   = code_q;
      done_d   = 1'b0;
      // busy trails the state by one cycle so it drops on the done edge
      busy_d   = (state_q == EXEC) || (state_q == ITER);

      s2_eff   = s2s_q ^ (op_q == OP_SUB);
      add_sum  = {1'b0, s1_q} + {1'b0, s2_q};
      chk_mag  = mag_q;
      chk_hi   = carry_q;
      chk_sign = rsign_q;
      ovf      = 1'b0;

      if (bus.i_clear_err) begin
         err_d  = 1'b0;
         code_d = ERR_NONE;
      end

      case (state_q)
         IDLE: if (accept) begin
            op_d  = bus.i_op;
            s1_d  = bus.i_s1;
            s2_d  = bus.i_s2;
            s1s_d = bus.i_s1_sign;
            s2s_d = bus.i_s2_sign;
            dz_d  = div_zero;
            if (!bus.i_op[1]) state_d = EXEC;
            else if (div_zero) state_d = CHECK;
            else state_d = ITER;
         end
         EXEC: begin
            if (s1s_q == s2_eff) begin
               mag_d   = add_sum[W-1:0];
               carry_d = add_sum[W];
               rsign_d = s1s_q;
            end else if (s1_q >= s2_q) begin
               mag_d   = s1_q - s2_q;
               carry_d = 1'b0;
               rsign_d = s1s_q;
            end else begin
               mag_d   = s2_q - s1_q;
               carry_d = 1'b0;
               rsign_d = s2_eff;
            end
            state_d = CHECK;
         end
         ITER: if (core_valid) state_d = CHECK;
         CHECK: begin
            if (op_q[1]) begin
               chk_mag  = core_p[W-1:0];
               chk_hi   = |core_p[2*W-1:W];
               chk_sign = s1s_q ^ s2s_q;
            end
            if (chk_mag == '0) chk_sign = 1'b0;
            ovf = chk_hi || (!chk_sign && chk_mag > POS_LIM) || (chk_sign && chk_mag > NEG_LIM);
            if (dz_q || ovf) begin
               result_d = '0;
               sign_d   = 1'b0;
               err_d    = 1'b1;
               code_d   = dz_q ? ERR_DZ : ERR_OVF;
            end else begin
               result_d = chk_mag;
               sign_d   = chk_sign;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= IDLE;
         op_q     <= OP_ADD;
         s1_q     <= '0;
         s2_q     <= '0;
         s1s_q    <= 1'b0;
         s2s_q    <= 1'b0;
         mag_q    <= '0;
         carry_q  <= 1'b0;
         rsign_q  <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
         sign_q   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= ERR_NONE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s1s_q    <= s1s_d;
         s2s_q    <= s2s_d;
         mag_q    <= mag_d;
         carry_q  <= carry_d;
         rsign_q  <= rsign_d;
         dz_q     <= dz_d;
         result_q <= result_d;
         sign_q   <= sign_d;
         err_q    <= err_d;
         code_q   <= code_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.o_busy     = busy_q;
   assign bus.o_done     = done_q;
   assign bus.o_result   = result_q;
   assign bus.o_sign     = sign_q;
   assign bus.o_err      = err_q;
   assign bus.o_err_code = code_q;
endmodule

// File: doc/calc_engine.md
# calc_engine

Parametrised sign-magnitude arithmetic engine for the calculator datapath of the digital clock. It accepts two signed BCD-range operands and an opcode through a start/busy/done handshake. Add and subtract finish in a single cycle; multiply and divide run on an iterative shift-add / restoring core. The result is range-checked against the display digit count, and a sticky, coded error is raised when it does not fit.

## Interface
- W, 40: operand/result magnitude width in bits.
- DIGITS, 6: display digits. Positive limit is 10^DIGITS−1; negative limit is 10^(DIGITS−1)−1 (one digit is used by the minus sign).
- i_clk  in  1  single clock; all logic on its rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_start  in  1  start request; sampled only in IDLE.
- i_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- i_s1, i_s2  in  W  operand magnitudes.
- i_s1_sign, i_s2_sign  in  1  operand signs, 1 = negative.
- i_clear_err  in  1  clears the sticky error.
- o_busy  out  1  high from the cycle after an accepted start until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_result  out  W  result magnitude.
- o_sign  out  1  result sign.
- o_err  out  1  sticky error flag.
- o_err_code  out  2  00 none, 01 overflow, 10 divide-by-zero.

## Operation
- **Start acceptance:** start is accepted only when state = IDLE, i_start = 1, o_err = 0 and i_clear_err = 0. Operands and op are latched on acceptance; input changes afterwards are ignored.
- **States and transitions:**
  - IDLE → EXEC on ADD/SUB.
  - IDLE → ITER on MUL/DIV with i_s2 ≠ 0.
  - IDLE → CHECK on DIV with i_s2 = 0; divide-by-zero is flagged.
  - EXEC → CHECK.
  - ITER runs exactly W cycles, then → CHECK.
  - CHECK → IDLE, pulsing o_done.
- **ADD/SUB:** effective sign of s2 is inverted for SUB.
  - Equal signs: magnitudes are added; result sign = common sign.
  - Different signs: smaller magnitude is subtracted from larger; result sign = sign of the larger.
  - Ties give a zero result.
- **MUL:** 2W-bit product via shift-add, one bit per cycle, LSB first. Result sign = s1_sign XOR s2_sign.
- **DIV:** restoring division, one quotient bit per cycle, MSB first. Quotient truncates toward zero; the remainder is discarded. Result sign = XOR of operand signs.
- **Zero results:** o_sign is forced to 0 whenever the magnitude is 0 (no "−0").
- **CHECK:** overflow is raised if any of these hold:
  - the upper W product bits are nonzero;
  - ADD carry-out is set;
  - the magnitude exceeds the positive limit when sign = 0;
  - the magnitude exceeds the negative limit when sign = 1.
- **On error:** o_result = 0, o_sign = 0, o_err = 1, o_err_code is set, and o_done still pulses.
- **Sticky error:** while o_err = 1, starts are ignored (no busy, no done). i_clear_err sets o_err = 0 and o_err_code = 00 the next cycle. o_result is unchanged.
- **Clear vs. start:** clear and start in the same IDLE cycle → clear wins and the start is dropped.
- **Start while busy:** ignored; it is not queued.

## Timing
- **Reset values:** state = IDLE, o_result = 0, o_sign = 0, o_err = 0, o_err_code = 00, o_busy = 0, o_done = 0.
- **Reset mid-operation:** aborts the operation; no o_done is produced, and all outputs take their reset values on the next edge.
- **Latency from the accepting edge (cycle 0):**
  - ADD/SUB: o_done at cycle 2.
  - MUL/DIV: o_done at cycle W+2.
  - DIV by zero: o_done at cycle 1.
- **Output update:** o_result, o_sign and o_err update on the same edge that asserts o_done, and hold until the next completion, clear or reset.
- **Back-to-back:** a new start is accepted the cycle o_done is high (state is IDLE).

## Structure
- **Package calc_pkg:** opcode constants, error-code constants, state enum (IDLE, EXEC, ITER, CHECK), and a function computing 10^n limits at elaboration.
- **Sub-module calc_seq_muldiv:** W-parameterised iterative core.
  - Inputs: load, mode (mul/div), a, b.
  - Outputs: 2W-bit product/quotient and a valid pulse after W cycles.
- **Top level:** the FSM, sign handling, add/sub and range check stay in calc_engine.

## Test plan
All cases use W=40, DIGITS=6.
- +123 ADD +877 → o_result 1000, o_sign 0, o_done at cycle 2, o_err 0.
- +5 SUB +12 → 7, o_sign 1. +12 SUB +12 → 0, o_sign 0.
- −5 MUL +3 → 15, o_sign 1, o_done at cycle 42, o_busy high for cycles 1–41. −7 DIV +2 → 3, o_sign 1.
- +100 DIV 0 → o_done at cycle 1, o_err 1, code 10, o_result 0. The next start is ignored. i_clear_err, then +9 ADD +1 → 10.
- +1000 MUL +1000 → overflow (code 01). −99999 SUB +1 → overflow. +999998 ADD +1 → 999999, no error.
- i_reset at cycle 10 of a DIV → no o_done ever, all outputs reset next cycle. A fresh start afterwards completes normally.
